seq_mem_ctrl: RTL and testbench

Controller that sequences and shares the 16-entry sequential memory. Two producers write through round-robin arbitration and one consumer drains entries in write order. It converts valid/ready handshakes into the memory's pulse-and-release request protocol and tracks the fill/drain session. When a session completes, it clears the memory for reuse.

---
 rtl/seq_mem_ctrl.sv | 154 +++++++++++++++
 tb/tb_seq_mem_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mem_ctrl.sv
// Front-end controller for the 16-entry sequential memory: two round-robin producers,
// one in-order consumer, handshakes turned into one-cycle memory request pulses.
module seq_mem_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr0_valid,
    input  logic [DATA_WIDTH-1:0] wr0_data,
    output logic                  wr0_ready,
    input  logic                  wr1_valid,
    input  logic [DATA_WIDTH-1:0] wr1_data,
    output logic                  wr1_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_ready,
    input  logic                  clear,
    output logic                  mem_reset,
    output logic                  mem_request_write,
    output logic                  mem_request_read,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic                  mem_correct_read,
    output logic [CW-1:0]         count_wr,
    output logic [CW-1:0]         count_rd,
    output logic                  done,
    output logic [2:0]            dbg_state
);

    // Handshakes: a word moves on a cycle where valid and ready are both high.
    // Ready/valid outputs are combinational and held at 0 while reset is asserted.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR_HI = 3'd1,
        S_WR_LO = 3'd2,
        S_RD_HI = 3'd3,
        S_RD_LO = 3'd4,
        S_DONE  = 3'd5,
        S_CLEAR = 3'd6
    } state_t;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    state_t                state_q, state_d;
    logic [CW-1:0]         count_wr_q, count_wr_d;
    logic [CW-1:0]         count_rd_q, count_rd_d;
    logic                  rr_q, rr_d;
    logic                  last_op_q, last_op_d;   // 1 = last op was a write
    logic [DATA_WIDTH-1:0] mem_data_in_q, mem_data_in_d;

    logic wr_cand;
    logic rd_possible;
    logic read_first;
    logic grant1;
    logic wr0_ready_c, wr1_ready_c, rd_valid_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            count_wr_q    <= '0;
            count_rd_q    <= '0;
            rr_q          <= 1'b0;
            last_op_q     <= 1'b0;
            mem_data_in_q <= '0;
        end else begin
            state_q       <= state_d;
            count_wr_q    <= count_wr_d;
            count_rd_q    <= count_rd_d;
            rr_q          <= rr_d;
            last_op_q     <= last_op_d;
            mem_data_in_q <= mem_data_in_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        count_wr_d    = count_wr_q;
        count_rd_d    = count_rd_q;
        rr_d          = rr_q;
        last_op_d     = last_op_q;
        mem_data_in_d = mem_data_in_q;
        wr0_ready_c   = 1'b0;
        wr1_ready_c   = 1'b0;
        rd_valid_c    = 1'b0;

        wr_cand     = (count_wr_q < DEPTH_C) && (wr0_valid || wr1_valid);
        rd_possible = (count_rd_q < count_wr_q) && mem_correct_read;
        // After a write, a ready consumer gets the next slot so reads are not starved.
        read_first  = last_op_q && rd_possible && rd_ready;
        grant1      = rr_q ? wr1_valid : !wr0_valid;

        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    state_d = S_CLEAR;
                end else if (wr_cand && !read_first) begin
                    wr0_ready_c   = !grant1;
                    wr1_ready_c   = grant1;
                    mem_data_in_d = grant1 ? wr1_data : wr0_data;
                    rr_d          = !grant1;
                    last_op_d     = 1'b1;
                    state_d       = S_WR_HI;
                end else if (rd_possible) begin
                    rd_valid_c = 1'b1;
                    if (rd_ready) begin
                        last_op_d = 1'b0;
                        state_d   = S_RD_HI;
                    end
                end
            end
            S_WR_HI: state_d = S_WR_LO;
            S_WR_LO: begin
                count_wr_d = count_wr_q + ONE_C;
                state_d    = S_IDLE;
            end
            S_RD_HI: state_d = S_RD_LO;
            S_RD_LO: begin
                count_rd_d = count_rd_q + ONE_C;
                state_d    = (count_rd_q + ONE_C == DEPTH_C) ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                if (clear) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                count_wr_d    = '0;
                count_rd_d    = '0;
                rr_d          = 1'b0;
                last_op_d     = 1'b0;
                mem_data_in_d = '0;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wr0_ready         = wr0_ready_c & ~reset;
    assign wr1_ready         = wr1_ready_c & ~reset;
    assign rd_valid          = rd_valid_c & ~reset;
    assign rd_data           = mem_data_out;
    // Requests decode straight from state so an async reset drops them immediately.
    assign mem_request_write = (state_q == S_WR_HI);
    assign mem_request_read  = (state_q == S_RD_HI);
    assign mem_reset         = reset | (state_q == S_CLEAR);
    assign mem_data_in       = mem_data_in_q;
    assign count_wr          = count_wr_q;
    assign count_rd          = count_rd_q;
    assign done              = (count_rd_q == DEPTH_C);
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_seq_mem_ctrl.sv
// Directed-plus-random bench for seq_mem_ctrl with a behavioural sequential memory
// and an in-order scoreboard of accepted words.
module tb_seq_mem_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_DONE = 3'd5;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr0_valid, wr1_valid;
    logic [DW-1:0] wr0_data, wr1_data;
    logic          wr0_ready, wr1_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_ready;
    logic          clear;
    logic          mem_reset, mem_request_write, mem_request_read;
    logic [DW-1:0] mem_data_in, mem_data_out;
    logic          mem_correct_read;
    logic [CW-1:0] count_wr, count_rd;
    logic          done;
    logic [2:0]    dbg_state;

    seq_mem_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .wr0_valid(wr0_valid), .wr0_data(wr0_data), .wr0_ready(wr0_ready),
        .wr1_valid(wr1_valid), .wr1_data(wr1_data), .wr1_ready(wr1_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .clear(clear), .mem_reset(mem_reset),
        .mem_request_write(mem_request_write), .mem_request_read(mem_request_read),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_correct_read(mem_correct_read),
        .count_wr(count_wr), .count_rd(count_rd), .done(done), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- sequential memory stub ----------------
    logic [DW-1:0] mem_arr [0:DEPTH-1];
    logic [4:0]    m_wp, m_rp;

    initial for (int i = 0; i < DEPTH; i++) mem_arr[i] = '0;

    always @(posedge clk) begin
        if (mem_reset) begin
            m_wp <= '0;
            m_rp <= '0;
        end else begin
            if (mem_request_write && m_wp < 5'(DEPTH)) begin
                mem_arr[m_wp[3:0]] <= mem_data_in;
                m_wp <= m_wp + 5'd1;
            end
            if (mem_request_read && m_rp < m_wp) m_rp <= m_rp + 5'd1;
        end
    end

    assign mem_data_out     = mem_arr[m_rp[3:0]];
    assign mem_correct_read = (m_rp != m_wp);

    // ---------------- scoreboard / checker ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    logic [DW-1:0] exp_q [$];
    int            ops [$];          // 0 = write accepted, 1 = read taken
    logic          m_rr = 1'b0;      // model round-robin pointer
    int            n_acc = 0;
    int            n_rd  = 0;
    int            mem_reset_cycles = 0;
    logic          prev_w = 1'b0, prev_r = 1'b0;
    int            w_gap = 99;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic who, exp_who;
        if (reset) begin
            prev_w = 1'b0;
            prev_r = 1'b0;
            w_gap  = 99;
        end else begin
            check("invariants",
                  32'({mem_request_write & mem_request_read,
                       wr0_ready & wr1_ready,
                       rd_valid & (wr0_ready | wr1_ready),
                       count_rd > count_wr}), 32'd0);
            if (mem_request_write) begin
                check("wr_pulse_width", 32'(prev_w), 32'd0);
                if (!prev_w && w_gap != 99) check("wr_pulse_gap", 32'(w_gap >= 2), 32'd1);
            end
            if (mem_request_read) check("rd_pulse_width", 32'(prev_r), 32'd0);
            w_gap  = mem_request_write ? 0 : ((w_gap == 99) ? 99 : w_gap + 1);
            prev_w = mem_request_write;
            prev_r = mem_request_read;
            if (mem_reset) mem_reset_cycles++;

            if ((wr0_valid && wr0_ready) || (wr1_valid && wr1_ready)) begin
                who     = wr1_valid && wr1_ready;
                exp_who = (wr0_valid && wr1_valid) ? m_rr : wr1_valid;
                check("rr_winner", 32'(who), 32'(exp_who));
                m_rr = !who;
                exp_q.push_back(who ? wr1_data : wr0_data);
                ops.push_back(0);
                n_acc++;
            end
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
                else check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
                ops.push_back(1);
                n_rd++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_state(input logic [2:0] s, input string tag);
        int k = 0;
        while (dbg_state !== s && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check(tag, 32'(dbg_state), 32'(s));
    endtask

    task automatic write0(input logic [DW-1:0] d, input string tag);
        int   k = 0;
        logic got = 1'b0;
        wr0_valid = 1'b1;
        wr0_data  = d;
        while (!got && k < 50) begin
            @(negedge clk);
            got = wr0_ready;
            @(posedge clk); #1;
            k++;
        end
        wr0_valid = 1'b0;
        check(tag, 32'(got), 32'd1);
    endtask

    task automatic read_n(input int n, input string tag);
        int k = 0;
        int target = n_rd + n;
        rd_ready = 1'b1;
        while (n_rd < target && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        rd_ready = 1'b0;
        check(tag, 32'(n_rd), 32'(target));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        exp_q.delete();
        m_rr = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int            k, base, seq, bad;
        logic          a0, a1;
        logic [DW-1:0] d;

        reset = 1'b1; clear = 1'b0; rd_ready = 1'b1;
        wr0_valid = 1'b1; wr1_valid = 1'b1;
        wr0_data = 8'h5A; wr1_data = 8'hA5;

        // 1: reset behaviour, with stimulus asserted to show outputs are gated
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_reset", 32'(mem_reset), 32'd1);
        check("rst_handshakes", 32'({wr0_ready, wr1_ready, rd_valid}), 32'd0);
        check("rst_requests", 32'({mem_request_write, mem_request_read}), 32'd0);
        check("rst_counts", 32'({count_wr, count_rd, done}), 32'd0);
        check("rst_mem_data_in", 32'(mem_data_in), 32'd0);
        @(posedge clk); #1;
        wr0_valid = 1'b0; wr1_valid = 1'b0; rd_ready = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("idle_mem_reset", 32'(mem_reset), 32'd0);
        check("idle_state", 32'(dbg_state), 32'(ST_IDLE));
        check("idle_handshakes", 32'({wr0_ready, wr1_ready, rd_valid, done}), 32'd0);
        @(posedge clk); #1;

        // 2: two writes from producer 0, then read back in order
        write0(8'h11, "w11_accepted");
        wait_state(ST_IDLE, "w11_idle");
        write0(8'h22, "w22_accepted");
        wait_state(ST_IDLE, "w22_idle");
        check("partial_no_rd_yet", 32'(n_rd), 32'd0);
        read_n(2, "read_two");
        wait_state(ST_IDLE, "read_two_idle");
        check("two_counts", 32'({count_wr, count_rd}), 32'({5'd2, 5'd2}));
        check("two_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        do_clear();
        wait_state(ST_IDLE, "clr1_idle");
        check("clr1_counts", 32'({count_wr, count_rd}), 32'd0);

        // 3: both producers always valid, fill the session, then drain it
        seq = $urandom_range(0, 60);
        wr0_data = {1'b0, 7'(seq)};
        wr1_data = {1'b1, 7'(seq)};
        wr0_valid = 1'b1; wr1_valid = 1'b1;
        base = n_acc; k = 0;
        while (n_acc - base < DEPTH && k < 200) begin
            @(negedge clk);
            a0 = wr0_ready; a1 = wr1_ready;
            @(posedge clk); #1;
            if (a0 || a1) seq++;
            if (a0) wr0_data = {1'b0, 7'(seq)};
            if (a1) wr1_data = {1'b1, 7'(seq)};
            k++;
        end
        check("fill_accepts", 32'(n_acc - base), 32'(DEPTH));
        wait_state(ST_IDLE, "fill_idle");
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (wr0_ready || wr1_ready) bad++;
        end
        check("full_no_ready", 32'(bad), 32'd0);
        check("full_count_wr", 32'(count_wr), 32'(DEPTH));
        @(posedge clk); #1;
        wr0_valid = 1'b0; wr1_valid = 1'b0;
        read_n(DEPTH, "drain_reads");
        wait_state(ST_DONE, "drain_done_state");
        @(negedge clk);
        check("drain_done", 32'(done), 32'd1);
        check("drain_count_rd", 32'(count_rd), 32'(DEPTH));
        check("drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        wr0_valid = 1'b1; rd_ready = 1'b1;
        @(negedge clk);
        check("done_outputs_low", 32'({wr0_ready, wr1_ready, rd_valid}), 32'd0);
        @(posedge clk); #1;
        wr0_valid = 1'b0; rd_ready = 1'b0;

        // 4: clear from DONE, then a new write is accepted
        mem_reset_cycles = 0;
        do_clear();
        wait_state(ST_IDLE, "clr2_idle");
        check("clr2_mem_reset_pulse", 32'(mem_reset_cycles), 32'd1);
        check("clr2_counts", 32'({count_wr, count_rd, done}), 32'd0);
        write0(8'($urandom_range(0, 255)), "post_clear_accepted");
        wait_state(ST_IDLE, "post_clear_idle");
        check("post_clear_count_wr", 32'(count_wr), 32'd1);

        // 5: clear a partial session, then continuous producer and consumer
        do_clear();
        wait_state(ST_IDLE, "clr3_idle");
        ops.delete();
        wr0_data = 8'($urandom_range(0, 255));
        wr0_valid = 1'b1; rd_ready = 1'b1;
        k = 0;
        while (!done && k < 400) begin
            @(negedge clk);
            a0 = wr0_ready;
            @(posedge clk); #1;
            if (a0) wr0_data = 8'($urandom_range(0, 255));
            k++;
        end
        wr0_valid = 1'b0; rd_ready = 1'b0;
        check("stream_done", 32'(done), 32'd1);
        check("stream_op_count", 32'(ops.size()), 32'(2 * DEPTH));
        bad = 0;
        foreach (ops[i]) if (ops[i] != (i % 2)) bad++;
        check("stream_alternation", 32'(bad), 32'd0);

        // 6: reset in the middle of a write pulse
        do_clear();
        wait_state(ST_IDLE, "clr4_idle");
        write0(8'($urandom_range(0, 255)), "pre_abort_accepted");
        wait_state(ST_IDLE, "pre_abort_idle");
        write0(8'hA5, "abort_accepted");
        check("abort_in_wr_hi", 32'(mem_request_write), 32'd1);
        #2;
        reset = 1'b1;
        exp_q.delete();
        m_rr = 1'b0;
        #1;
        check("abort_req_dropped", 32'(mem_request_write), 32'd0);
        check("abort_count_wr", 32'(count_wr), 32'd0);
        check("abort_mem_reset", 32'(mem_reset), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        d = 8'($urandom_range(0, 255));
        write0(d, "recover_first_accepted");
        wait_state(ST_IDLE, "recover_first_idle");
        write0(~d, "recover_second_accepted");
        wait_state(ST_IDLE, "recover_second_idle");
        check("recover_count_wr", 32'(count_wr), 32'd2);
        read_n(1, "recover_read");
        wait_state(ST_IDLE, "recover_read_idle");
        check("recover_remaining", 32'(exp_q.size()), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
